stepper_ramp_ctrl: RTL and testbench
====================================

STEPPER_RAMP_CTRL -- requirements
Module: stepper_ramp_ctrl

Interface
REQ-001 SHALL have parameter PER_W, default 24: width of step-period values, in clock cycles.
REQ-002 SHALL have parameter CNT_W, default 16: width of the step count.
REQ-003 SHALL have parameter POS_W, default 32: width of the signed position register.
REQ-004 SHALL have parameter START_PER, default 50000: start/stop step period, in cycles.
REQ-005 SHALL have parameter MIN_PER, default 5000: fastest allowed step period.
REQ-006 SHALL have parameter ACC_DELTA, default 500: period change per step while ramping.
REQ-007 SHALL have parameter HOLD_EN, default 0: 1 keeps coils energised when idle; 0 drives coils to 0.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port resetb, input, 1 bit: synchronous, active-high reset (asserted = 1).
REQ-010 SHALL have port cmd_valid, input, 1 bit: move request.
REQ-011 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-012 SHALL have port cmd_steps, input, CNT_W bits: number of steps.
REQ-013 SHALL have port cmd_dir, input, 1 bit: 1 = forward (index +), 0 = reverse.
REQ-014 SHALL have port cmd_mode, input, 2 bits: 0 = wave, 1 = full, 2 = half, 3 = reserved (treated as half).
REQ-015 SHALL have port cmd_period, input, PER_W bits: requested cruise period.
REQ-016 SHALL have port stop, input, 1 bit: graceful decelerating abort.
REQ-017 SHALL have port coils, output, 4 bits: coil drive pattern.
REQ-018 SHALL have port step_pulse, output, 1 bit: one-cycle strobe per step.
REQ-019 SHALL have port busy, output, 1 bit: high when not IDLE.
REQ-020 SHALL have port done, output, 1 bit: one-cycle strobe at move end.
REQ-021 SHALL have port position, output, POS_W bits: signed step position.

Function
REQ-022 SHALL use the 8-entry phase table, indices 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-023 SHALL drive coils = table[index] when busy; when idle, coils = table[index] if HOLD_EN = 1, else 0000.
REQ-024 SHALL accept a command on the cycle cmd_valid & cmd_ready & ~stop, latching steps, dir, mode and target.
REQ-025 SHALL compute target = clamp(cmd_period, MIN_PER, START_PER).
REQ-026 SHALL, on accept, align the index without a step: wave clears bit0; full sets bit0; half leaves the index unchanged.
REQ-027 SHALL advance the index by ±2 (wave/full) or ±1 (half) on each step, modulo 8.
REQ-028 SHALL, on each step, pulse step_pulse and change position by ±1 (two's-complement wrap).
REQ-029 SHALL use FSM states IDLE, ACCEL, CRUISE, DECEL.
REQ-030 SHALL, on accept, enter ACCEL with period = START_PER and ramp_cnt = 0, or CRUISE if target = START_PER.
REQ-031 SHALL make step k occur exactly P(k) cycles after step k-1; for k = 1, P(1) = START_PER cycles after the accept cycle.
REQ-032 SHALL, after each step, first decrement remaining.
REQ-033 SHALL then, if remaining = 0, go to IDLE, pulse done and clear busy in the same cycle.
REQ-034 SHALL otherwise, in ACCEL or CRUISE with remaining ≤ ramp_cnt, enter DECEL.
REQ-035 SHALL otherwise, in ACCEL, set period = max(period − ACC_DELTA, target) and ramp_cnt++, entering CRUISE when period = target.
REQ-036 SHALL, on every step taken in DECEL (including the one that enters DECEL), set period = min(period + ACC_DELTA, START_PER) and decrement ramp_cnt (saturating at 0).
REQ-037 SHALL, on cmd_steps = 0, accept, pulse done one cycle later, and produce no step.
REQ-038 SHALL, on stop in ACCEL/CRUISE, enter DECEL and set remaining = min(remaining, ramp_cnt + 1); the running step timer is unaffected.
REQ-039 SHALL ignore stop in IDLE or DECEL.
REQ-040 SHALL block acceptance while stop = 1.
REQ-041 SHALL ignore cmd_valid while busy.

Reset
REQ-042 SHALL, on resetb = 1 at a clock edge, set state IDLE, index 0, position 0, remaining 0, ramp_cnt 0, period START_PER, timer 0.
REQ-043 SHALL hold outputs at coils 0000, step_pulse 0, done 0, busy 0, cmd_ready 1 from the cycle after a reset edge.
REQ-044 SHALL allow reset mid-move: coils off at once, no done pulse.

Structure
REQ-045 SHALL put the phase table, the mode and state encodings, and the mode-to-increment function in shared package stepper_pkg.
REQ-046 SHALL place the step timer (reload/countdown/expire) in sub-module stepper_step_timer.

Verification (bench params START_PER=100, MIN_PER=20, ACC_DELTA=10)
REQ-047 SHALL cover: steps=5, period=80, half, dir=1, index 0 -> intervals 100, 90, 80, 90, 100; coils 1100, 0100, 0110, 0010, 0011; position 5; done once.
REQ-048 SHALL cover: steps=3, period=10 (clamped to 20) -> intervals 100, 90, 100; triangular profile.
REQ-049 SHALL cover: steps=20, period=80, stop one cycle after the 4th step (CRUISE, ramp_cnt = 2) -> exactly 3 further steps at 80, 90, 100, then done.
REQ-050 SHALL cover: wave mode, dir=0, from index 3 -> align to 2 (coils 0100), steps 0, 6, 4; position −3.
REQ-051 SHALL cover: steps=0 -> done one cycle after accept; no step_pulse; position unchanged.
REQ-052 SHALL cover: resetb asserted between steps 2 and 3 -> next cycle coils 0000, busy 0, position 0, no done.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper ramp controller: coil phase table,
// drive-mode and FSM encodings, and index helpers.
package stepper_pkg;

   typedef enum logic [1:0] {
      MODE_WAVE = 2'd0,
      MODE_FULL = 2'd1,
      MODE_HALF = 2'd2,
      MODE_RSVD = 2'd3
   } step_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEL  = 2'd1,
      ST_CRUISE = 2'd2,
      ST_DECEL  = 2'd3
   } step_state_e;

   // Entry [i] is the coil pattern for phase index i (leftmost literal is index 7).
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

   function automatic logic [2:0] mode_incr(input step_mode_e mode);
      logic [2:0] inc;
      case (mode)
         MODE_WAVE, MODE_FULL: inc = 3'd2;
         default:              inc = 3'd1;
      endcase
      return inc;
   endfunction

   // Wave uses even (single-coil) phases, full uses odd (two-coil) phases.
   function automatic logic [2:0] align_index(input step_mode_e mode,
                                              input logic [2:0] idx);
      logic [2:0] aligned;
      case (mode)
         MODE_WAVE: aligned = {idx[2:1], 1'b0};
         MODE_FULL: aligned = {idx[2:1], 1'b1};
         default:   aligned = idx;
      endcase
      return aligned;
   endfunction

endpackage

// File: rtl/stepper_step_timer.sv
// Step interval timer: load a period, count down, flag the cycle whose
// closing edge is the step edge.
module stepper_step_timer #(
   parameter int PER_W = 24
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             load_i,
   input  logic [PER_W-1:0] load_val_i,
   output logic             expire_o
);

   localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

   logic [PER_W-1:0] cnt_q;
   logic [PER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - PER_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (resetb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A count of 1 means the next edge is exactly load_val cycles after the load edge.
   assign expire_o = (cnt_q == PER_ONE);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Stepper motor controller with trapezoidal speed ramp: accepts a move command,
// accelerates from START_PER towards the requested period, cruises, and decelerates.
module stepper_ramp_ctrl
   import stepper_pkg::*;
#(
   parameter int PER_W     = 24,
   parameter int CNT_W     = 16,
   parameter int POS_W     = 32,
   parameter int START_PER = 50000,
   parameter int MIN_PER   = 5000,
   parameter int ACC_DELTA = 500,
   parameter int HOLD_EN   = 0
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [CNT_W-1:0]        cmd_steps,
   input  logic                    cmd_dir,
   input  logic [1:0]              cmd_mode,
   input  logic [PER_W-1:0]        cmd_period,
   input  logic                    stop,
   output logic [3:0]              coils,
   output logic                    step_pulse,
   output logic                    busy,
   output logic                    done,
   output logic signed [POS_W-1:0] position
);

   localparam logic [PER_W-1:0] START_P = PER_W'(START_PER);
   localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PER);
   localparam logic [PER_W-1:0] DELTA_P = PER_W'(ACC_DELTA);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   CNT_ONE_X = (CNT_W+1)'(1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   step_state_e      state_q,      state_d;
   step_mode_e       mode_q,       mode_d;
   logic             dir_q,        dir_d;
   logic [2:0]       index_q,      index_d;
   logic [POS_W-1:0] position_q,   position_d;
   logic [CNT_W-1:0] remaining_q,  remaining_d;
   logic [CNT_W-1:0] ramp_q,       ramp_d;
   logic [PER_W-1:0] period_q,     period_d;
   logic [PER_W-1:0] target_q,     target_d;
   logic             step_pulse_q, step_pulse_d;
   logic             done_q,       done_d;

   logic             timer_load;
   logic [PER_W-1:0] timer_val;
   logic             timer_expire;
   logic [PER_W-1:0] clamped_per;
   logic [CNT_W-1:0] rem_dec;
   logic [2:0]       inc;

   stepper_step_timer #(
      .PER_W (PER_W)
   ) u_step_timer (
      .clk        (clk),
      .resetb     (resetb),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .expire_o   (timer_expire)
   );

   always_comb begin
      clamped_per = cmd_period;
      if (cmd_period < MIN_P) begin
         clamped_per = MIN_P;
      end else if (cmd_period > START_P) begin
         clamped_per = START_P;
      end
   end

   // Command handshake: a move is taken on the cycle cmd_valid & cmd_ready & ~stop;
   // cmd_ready is high exactly in IDLE, and cmd_valid is ignored otherwise.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      dir_d        = dir_q;
      index_d      = index_q;
      position_d   = position_q;
      remaining_d  = remaining_q;
      ramp_d       = ramp_q;
      period_d     = period_q;
      target_d     = target_q;
      step_pulse_d = 1'b0;
      done_d       = 1'b0;
      timer_load   = 1'b0;
      timer_val    = '0;
      rem_dec      = remaining_q - CNT_ONE;
      inc          = mode_incr(mode_q);

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && !stop) begin
               mode_d   = step_mode_e'(cmd_mode);
               dir_d    = cmd_dir;
               target_d = clamped_per;
               index_d  = align_index(step_mode_e'(cmd_mode), index_q);
               if (cmd_steps == '0) begin
                  done_d = 1'b1;
               end else begin
                  remaining_d = cmd_steps;
                  ramp_d      = '0;
                  period_d    = START_P;
                  state_d     = (clamped_per == START_P) ? ST_CRUISE : ST_ACCEL;
                  timer_load  = 1'b1;
                  timer_val   = START_P;
               end
            end
         end

         default: begin
            if (timer_expire) begin
               step_pulse_d = 1'b1;
               index_d      = dir_q ? (index_q + inc) : (index_q - inc);
               position_d   = dir_q ? (position_q + POS_ONE) : (position_q - POS_ONE);
               remaining_d  = rem_dec;
               if (rem_dec == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  if (state_q != ST_DECEL && rem_dec <= ramp_q) begin
                     state_d = ST_DECEL;
                  end
                  if (state_d == ST_DECEL) begin
                     period_d = (START_P - period_q > DELTA_P) ? (period_q + DELTA_P) : START_P;
                     ramp_d   = (ramp_q == '0) ? '0 : (ramp_q - CNT_ONE);
                  end else if (state_q == ST_ACCEL) begin
                     period_d = (period_q - target_q > DELTA_P) ? (period_q - DELTA_P) : target_q;
                     ramp_d   = ramp_q + CNT_ONE;
                     if (period_d == target_q) begin
                        state_d = ST_CRUISE;
                     end
                  end
                  timer_load = 1'b1;
                  timer_val  = period_d;
               end
            end
            // Abort keeps just enough steps to walk the ramp back down; timer untouched.
            if (stop && (state_d == ST_ACCEL || state_d == ST_CRUISE)) begin
               state_d = ST_DECEL;
               if ({1'b0, remaining_d} > ({1'b0, ramp_d} + CNT_ONE_X)) begin
                  remaining_d = ramp_d + CNT_ONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetb) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_WAVE;
         dir_q        <= 1'b0;
         index_q      <= '0;
         position_q   <= '0;
         remaining_q  <= '0;
         ramp_q       <= '0;
         period_q     <= START_P;
         target_q     <= START_P;
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         dir_q        <= dir_d;
         index_q      <= index_d;
         position_q   <= position_d;
         remaining_q  <= remaining_d;
         ramp_q       <= ramp_d;
         period_q     <= period_d;
         target_q     <= target_d;
         step_pulse_q <= step_pulse_d;
         done_q       <= done_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign step_pulse = step_pulse_q;
   assign done       = done_q;
   assign position   = position_q;
   assign coils      = (busy || HOLD_EN != 0) ? PHASE_TABLE[index_q] : 4'b0000;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: directed ramp/stop/reset scenarios plus random
// moves, all checked against a step-level motion profile model.
module tb_stepper_ramp_ctrl;

   localparam int PER_W     = 24;
   localparam int CNT_W     = 16;
   localparam int POS_W     = 32;
   localparam int START_PER = 100;
   localparam int MIN_PER   = 20;
   localparam int ACC_DELTA = 10;
   localparam int HOLD_EN   = 0;

   localparam int PH_ACCEL  = 0;
   localparam int PH_CRUISE = 1;
   localparam int PH_DECEL  = 2;

   logic                    clk = 1'b0;
   logic                    resetb = 1'b1;
   logic                    cmd_valid = 1'b0;
   logic                    cmd_ready;
   logic [CNT_W-1:0]        cmd_steps = '0;
   logic                    cmd_dir = 1'b0;
   logic [1:0]              cmd_mode = 2'd0;
   logic [PER_W-1:0]        cmd_period = '0;
   logic                    stop = 1'b0;
   logic [3:0]              coils;
   logic                    step_pulse;
   logic                    busy;
   logic                    done;
   logic signed [POS_W-1:0] position;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [3:0]  tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
   int m_idx = 0;
   int m_pos = 0;

   stepper_ramp_ctrl #(
      .PER_W     (PER_W),
      .CNT_W     (CNT_W),
      .POS_W     (POS_W),
      .START_PER (START_PER),
      .MIN_PER   (MIN_PER),
      .ACC_DELTA (ACC_DELTA),
      .HOLD_EN   (HOLD_EN)
   ) dut (
      .clk        (clk),
      .resetb     (resetb),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_dir    (cmd_dir),
      .cmd_mode   (cmd_mode),
      .cmd_period (cmd_period),
      .stop       (stop),
      .coils      (coils),
      .step_pulse (step_pulse),
      .busy       (busy),
      .done       (done),
      .position   (position)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] idle_coils(input int idx);
      return (HOLD_EN != 0) ? tbl[idx] : 4'b0000;
   endfunction

   // Step-by-step interval list of a whole move, built from the ramp rules.
   function automatic void plan(input int steps, input int target, input int stop_after);
      int period, ramp, rem, phase, k;
      exp_q.delete();
      period = START_PER;
      ramp   = 0;
      rem    = steps;
      k      = 0;
      phase  = (target == START_PER) ? PH_CRUISE : PH_ACCEL;
      while (rem > 0) begin
         exp_q.push_back(32'(period));
         k++;
         rem--;
         if (rem == 0) break;
         if (phase != PH_DECEL && rem <= ramp) phase = PH_DECEL;
         if (phase == PH_DECEL) begin
            period = (period + ACC_DELTA > START_PER) ? START_PER : period + ACC_DELTA;
            ramp   = (ramp > 0) ? ramp - 1 : 0;
         end else if (phase == PH_ACCEL) begin
            period = (period - ACC_DELTA < target) ? target : period - ACC_DELTA;
            ramp++;
            if (period == target) phase = PH_CRUISE;
         end
         if (k == stop_after && phase != PH_DECEL) begin
            phase = PH_DECEL;
            if (rem > ramp + 1) rem = ramp + 1;
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      resetb    = 1'b1;
      cmd_valid = 1'b0;
      stop      = 1'b0;
      @(negedge clk);
      resetb = 1'b0;
      m_idx  = 0;
      m_pos  = 0;
   endtask

   task automatic run_move(input int steps, input bit dir, input int mode,
                           input int per, input int stop_after, input string name);
      int target, inc, total, n_plan, elapsed, last_at, n_steps, stray;
      bit finished;
      target = (per < MIN_PER) ? MIN_PER : ((per > START_PER) ? START_PER : per);
      plan(steps, target, stop_after);
      n_plan = exp_q.size();
      total  = 0;
      foreach (exp_q[i]) total += int'(exp_q[i]);
      if (mode == 0) m_idx = m_idx & 6;
      else if (mode == 1) m_idx = m_idx | 1;
      inc = (mode < 2) ? 2 : 1;

      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_steps  = CNT_W'(steps);
      cmd_dir    = dir;
      cmd_mode   = 2'(mode);
      cmd_period = PER_W'(per);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val({name, "_busy_after_accept"}, 32'(busy), 32'(steps != 0));
      check_val({name, "_coils_after_accept"}, 32'(coils),
                32'((steps != 0) ? tbl[m_idx] : idle_coils(m_idx)));

      elapsed  = 0;
      last_at  = 0;
      n_steps  = 0;
      finished = 1'b0;
      while (!finished && elapsed <= total + 4) begin
         if (step_pulse) begin
            n_steps++;
            if (exp_q.size() > 0) check_val({name, "_interval"}, elapsed - last_at, exp_q.pop_front());
            last_at = elapsed;
            m_idx = dir ? (m_idx + inc) % 8 : (m_idx + 8 - inc) % 8;
            m_pos = dir ? m_pos + 1 : m_pos - 1;
            check_val({name, "_coils"}, 32'(coils),
                      32'((n_steps == n_plan) ? idle_coils(m_idx) : tbl[m_idx]));
            check_val({name, "_position"}, position, m_pos);
         end
         if (done) begin
            check_val({name, "_done_time"}, elapsed, total);
            check_val({name, "_busy_at_done"}, 32'(busy), 32'd0);
            finished = 1'b1;
         end
         stop = (stop_after != 0) && step_pulse && (n_steps == stop_after);
         if (!finished) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_steps = CNT_W'($urandom_range(0, 20));
            @(negedge clk);
            elapsed++;
         end
      end
      cmd_valid = 1'b0;
      stop      = 1'b0;
      check_val({name, "_finished"}, 32'(finished), 32'd1);
      check_val({name, "_step_count"}, n_steps, n_plan);
      check_val({name, "_final_position"}, position, m_pos);
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         if (step_pulse || done) stray++;
      end
      check_val({name, "_no_stray_pulse"}, stray, 0);
   endtask

   task automatic stop_blocks_accept();
      @(negedge clk);
      cmd_valid  = 1'b1;
      stop       = 1'b1;
      cmd_steps  = CNT_W'(5);
      cmd_mode   = 2'd2;
      cmd_period = PER_W'(50);
      @(negedge clk);
      check_val("stop_block_busy", 32'(busy), 32'd0);
      check_val("stop_block_done", 32'(done), 32'd0);
      check_val("stop_block_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic reset_mid_move();
      int seen, stray;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_steps  = CNT_W'(10);
      cmd_dir    = 1'b1;
      cmd_mode   = 2'd2;
      cmd_period = PER_W'(60);
      @(negedge clk);
      cmd_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 400 && seen < 2; c++) begin
         @(negedge clk);
         if (step_pulse) seen++;
      end
      check_val("rst_mid_steps_before", seen, 2);
      repeat (10) @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
      resetb = 1'b0;
      m_idx  = 0;
      m_pos  = 0;
      check_val("rst_mid_coils", 32'(coils), 32'd0);
      check_val("rst_mid_busy", 32'(busy), 32'd0);
      check_val("rst_mid_position", position, 32'd0);
      check_val("rst_mid_done", 32'(done), 32'd0);
      check_val("rst_mid_ready", 32'(cmd_ready), 32'd1);
      stray = 0;
      repeat (150) begin
         @(negedge clk);
         if (step_pulse || done) stray++;
      end
      check_val("rst_mid_quiet", stray, 0);
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      resetb = 1'b1;
      repeat (3) @(negedge clk);
      check_val("reset_coils", 32'(coils), 32'd0);
      check_val("reset_busy", 32'(busy), 32'd0);
      check_val("reset_ready", 32'(cmd_ready), 32'd1);
      check_val("reset_step_pulse", 32'(step_pulse), 32'd0);
      check_val("reset_done", 32'(done), 32'd0);
      check_val("reset_position", position, 32'd0);
      resetb = 1'b0;

      run_move(5, 1'b1, 2, 80, 0, "half_ramp5");
      run_move(3, 1'b1, 1, 10, 0, "triangle3");
      run_move(20, 1'b0, 0, 80, 4, "stop_after4");
      do_reset();
      run_move(3, 1'b1, 2, 50, 0, "half_to_idx3");
      run_move(3, 1'b0, 0, 50, 0, "wave_rev3");
      run_move(0, 1'b1, 1, 50, 0, "zero_steps");
      run_move(4, 1'b1, 3, 150, 0, "rsvd_cruise");
      stop_blocks_accept();
      reset_mid_move();

      for (int r = 0; r < 14; r++) begin
         int st, sa;
         st = $urandom_range(0, 12);
         sa = 0;
         if (st >= 3 && $urandom_range(0, 1) == 1) sa = $urandom_range(1, st - 1);
         run_move(st, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 130), sa, $sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
